// File: rtl/fifo_word_serializer_pkg.sv
// Shared types and constants for the FIFO word serializer.
// FIFO_SER_SYNC_HDR_EN adds one sync byte ahead of every word.
package fifo_ser_pkg;

  typedef enum logic [1:0] {IDLE, POP, LOAD, SEND} state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

`ifdef FIFO_SER_SYNC_HDR_EN
  localparam int HDR_BYTES = 1;
`else
  localparam int HDR_BYTES = 0;
`endif

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8 + HDR_BYTES;
  endfunction

endpackage

// File: rtl/fifo_word_serializer_if.sv
// FIFO read side and byte-stream side of the serializer.
// The master modport is the serializer; the slave modport is the FIFO and transmitter.
interface fifo_word_serializer_if #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
);
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_rd_en;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic [CNT_W-1:0]  word_cnt;

  modport master (
    input  fifo_empty, fifo_data, tx_ready,
    output fifo_rd_en, tx_data, tx_valid, busy, word_cnt
  );

  modport slave (
    output fifo_empty, fifo_data, tx_ready,
    input  fifo_rd_en, tx_data, tx_valid, busy, word_cnt
  );
endinterface

// File: rtl/fifo_word_serializer.sv
// Pops words from a registered-read FIFO and sends them as bytes on a valid/ready stream.
// Build with FIFO_SER_SYNC_HDR_EN to prefix each word with SYNC_BYTE.
module fifo_word_serializer
  import fifo_ser_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int MSB_FIRST = 1,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  fifo_word_serializer_if.master bus
);

  localparam int BPW   = bytes_per_word(DATA_W);
  localparam int IDX_W = $clog2(BPW);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q;
  logic [CNT_W-1:0]  word_cnt_q, word_cnt_d;

  function automatic logic [7:0] data_byte(input logic [DATA_W-1:0] w, input int j);
    if (MSB_FIRST != 0) return w[DATA_W-1-8*j -: 8];
    else                return w[8*j +: 8];
  endfunction

  // Byte k of the outgoing sequence, header included when enabled.
  function automatic logic [7:0] seq_byte(input logic [DATA_W-1:0] w, input int k);
`ifdef FIFO_SER_SYNC_HDR_EN
    if (k == 0) return SYNC_BYTE;
    return data_byte(w, k - 1);
`else
    return data_byte(w, k);
`endif
  endfunction

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    rd_en_d    = 1'b0;
    word_cnt_d = word_cnt_q;
    case (state_q)
      IDLE: begin
        if (!bus.fifo_empty) begin
          state_d = POP;
          rd_en_d = 1'b1;
        end
      end
      POP: state_d = LOAD;
      LOAD: begin
        // FIFO data landed at the POP edge, so it is valid here.
        shreg_d    = bus.fifo_data;
        idx_d      = '0;
        tx_data_d  = seq_byte(bus.fifo_data, 0);
        tx_valid_d = 1'b1;
        state_d    = SEND;
      end
      SEND: begin
        if (tx_valid_q && bus.tx_ready) begin
          if (idx_q == IDX_W'(BPW - 1)) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
            tx_valid_d = 1'b0;
            if (!bus.fifo_empty) begin
              state_d = POP;
              rd_en_d = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d     = idx_q + IDX_W'(1);
            tx_data_d = seq_byte(shreg_q, int'(idx_q) + 1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      shreg_q    <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= (state_d != IDLE);
      word_cnt_q <= word_cnt_d;
    end
  end

  assign bus.fifo_rd_en = rd_en_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.busy       = busy_q;
  assign bus.word_cnt   = word_cnt_q;

endmodule

// File: tb/tb_fifo_word_serializer.sv
// Scoreboard bench: two serializers (MSB-first and LSB-first) fed by FIFO models.
module tb_fifo_word_serializer;
  import fifo_ser_pkg::*;

  localparam int BPW = bytes_per_word(64);

  logic clk = 1'b0;
  logic rst;
  logic rdy0, rdy1;
  always #5 clk = ~clk;

  fifo_word_serializer_if #(.DATA_W(64), .CNT_W(16)) bm ();
  fifo_word_serializer_if #(.DATA_W(64), .CNT_W(16)) bl ();

  fifo_word_serializer #(.DATA_W(64), .MSB_FIRST(1), .CNT_W(16)) dut_m (
    .clk(clk), .rst(rst), .bus(bm.master));
  fifo_word_serializer #(.DATA_W(64), .MSB_FIRST(0), .CNT_W(16)) dut_l (
    .clk(clk), .rst(rst), .bus(bl.master));

  logic [63:0] mem0 [64];
  logic [63:0] mem1 [64];
  int wr0 = 0, rd0 = 0, wr1 = 0, rd1 = 0;
  int cyc = 0;

  assign bm.fifo_empty = (wr0 == rd0);
  assign bl.fifo_empty = (wr1 == rd1);
  assign bm.tx_ready   = rdy0;
  assign bl.tx_ready   = rdy1;

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk);
    if (bm.fifo_rd_en) begin
      bm.fifo_data <= mem0[rd0];
      rd0 <= rd0 + 1;
    end
    if (bl.fifo_rd_en) begin
      bl.fifo_data <= mem1[rd1];
      rd1 <= rd1 + 1;
    end
  end

  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  int n_chk = 0, n_pass = 0;
  int rxc[2];
  int rdp[2];
  int tcyc0[$];
  logic pv[2], prd[2];
  logic [7:0] pd[2];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
  endtask

  // exp_seq holds the hand-written byte order, first byte in the top octet.
  task automatic push_word(input int ch, input logic [63:0] w, input logic [63:0] exp_seq);
    logic [7:0] b;
`ifdef FIFO_SER_SYNC_HDR_EN
    if (ch == 0) exp0.push_back(8'hA5); else exp1.push_back(8'hA5);
`endif
    for (int k = 0; k < 8; k++) begin
      b = 8'((exp_seq >> (56 - 8 * k)) & 64'hFF);
      if (ch == 0) exp0.push_back(b); else exp1.push_back(b);
    end
    if (ch == 0) begin mem0[wr0] = w; wr0++; end
    else         begin mem1[wr1] = w; wr1++; end
  endtask

  task automatic mon_step(input int ch, input logic vld, input logic rdy, input logic [7:0] dat,
                          input logic rden, input logic empty);
    logic [7:0] e;
    int qs;
    if (pv[ch]) begin
      check("stall_valid_held", vld, 1'b1);
      check("stall_data_held", dat, pd[ch]);
    end
    if (vld && rdy) begin
      qs = (ch == 0) ? exp0.size() : exp1.size();
      check("byte_expected", (qs != 0), 1'b1);
      if (qs != 0) begin
        e = (ch == 0) ? exp0.pop_front() : exp1.pop_front();
        check(ch == 0 ? "byte_msb" : "byte_lsb", dat, e);
      end
      rxc[ch]++;
      if (ch == 0) tcyc0.push_back(cyc);
    end
    pv[ch] = vld && !rdy;
    pd[ch] = dat;
    if (rden) begin
      rdp[ch]++;
      check("rd_en_on_nonempty", empty, 1'b0);
      check("rd_en_single_pulse", prd[ch], 1'b0);
    end
    prd[ch] = rden;
  endtask

  initial forever begin
    @(negedge clk);
    if (rst) begin
      pv[0] = 1'b0; pv[1] = 1'b0; prd[0] = 1'b0; prd[1] = 1'b0;
    end else begin
      mon_step(0, bm.tx_valid, bm.tx_ready, bm.tx_data, bm.fifo_rd_en, bm.fifo_empty);
      mon_step(1, bl.tx_valid, bl.tx_ready, bl.tx_data, bl.fifo_rd_en, bl.fifo_empty);
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_rx(input int ch, input int n);
    int t = 0;
    while (rxc[ch] < n && t < 2000) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("bytes_received", rxc[ch], n);
  endtask

  task automatic check_reset_outputs();
    check("rst_tx_valid", bm.tx_valid, 1'b0);
    check("rst_tx_data", bm.tx_data, 8'h00);
    check("rst_rd_en", bm.fifo_rd_en, 1'b0);
    check("rst_busy", bm.busy, 1'b0);
    check("rst_word_cnt", bm.word_cnt, 16'd0);
    check("rst_word_cnt_lsb", bl.word_cnt, 16'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int c0, b;
    rxc[0] = 0; rxc[1] = 0; rdp[0] = 0; rdp[1] = 0;
    pv[0] = 1'b0; pv[1] = 1'b0; prd[0] = 1'b0; prd[1] = 1'b0;
    pd[0] = 8'h00; pd[1] = 8'h00;
    rdy0 = 1'b1;
    rdy1 = 1'b1;
    rst  = 1'b1;
    #2;
    check_reset_outputs();
    step(3);
    rst = 1'b0;
    step(2);

    // Single word, MSB first.
    c0 = cyc;
    push_word(0, 64'h0011_2233_4455_6677, 64'h0011_2233_4455_6677);
    wait_rx(0, BPW);
    check("first_byte_latency", tcyc0[0] - c0, 3);
    check("bytes_consecutive", tcyc0[BPW-1] - tcyc0[0], BPW - 1);
    step(3);
    check("single_rd_pulses", rdp[0], 1);
    check("single_word_cnt", bm.word_cnt, 16'd1);
    check("single_busy_idle", bm.busy, 1'b0);
    check("single_valid_idle", bm.tx_valid, 1'b0);

    // Three words back to back.
    push_word(0, 64'h8899_AABB_CCDD_EEFF, 64'h8899_AABB_CCDD_EEFF);
    push_word(0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);
    push_word(0, 64'hFEDC_BA98_7654_3210, 64'hFEDC_BA98_7654_3210);
    wait_rx(0, 4 * BPW);
    check("b2b_gap_1", tcyc0[2*BPW] - tcyc0[2*BPW-1], 3);
    check("b2b_gap_2", tcyc0[3*BPW] - tcyc0[3*BPW-1], 3);
    check("b2b_word_span", tcyc0[3*BPW-1] - tcyc0[2*BPW], BPW - 1);
    step(3);
    check("b2b_rd_pulses", rdp[0], 4);
    check("b2b_word_cnt", bm.word_cnt, 16'd4);

    // Backpressure with ready pattern 1,0,0,1.
    push_word(0, 64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D);
    for (int i = 0; i < 100 && rxc[0] < 5 * BPW; i++) begin
      @(posedge clk);
      #1;
      rdy0 = (i % 4 == 0) || (i % 4 == 3);
    end
    rdy0 = 1'b1;
    wait_rx(0, 5 * BPW);
    step(3);
    check("bp_word_cnt", bm.word_cnt, 16'd5);
    check("bp_busy_idle", bm.busy, 1'b0);

    // LSB-first instance.
    push_word(1, 64'h0011_2233_4455_6677, 64'h7766_5544_3322_1100);
    wait_rx(1, BPW);
    step(3);
    check("lsb_word_cnt", bl.word_cnt, 16'd1);
    check("lsb_rd_pulses", rdp[1], 1);

    // Reset after the third byte of a word, one more word queued behind it.
    b = rxc[0];
    push_word(0, 64'h1122_3344_5566_7788, 64'h1122_3344_5566_7788);
    push_word(0, 64'h99AA_BBCC_DDEE_FF00, 64'h99AA_BBCC_DDEE_FF00);
    wait_rx(0, b + 3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    while (exp0.size() > BPW) void'(exp0.pop_front());
    rxc[0] = b + 3;
    step(2);
    rst = 1'b0;
    wait_rx(0, b + 3 + BPW);
    step(3);
    check("post_reset_word_cnt", bm.word_cnt, 16'd1);
    check("post_reset_busy", bm.busy, 1'b0);

    check("scoreboard_drained_msb", exp0.size(), 0);
    check("scoreboard_drained_lsb", exp1.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
